// File: rtl/ipsxe_floating_point_apm_share_arb_v1_0_if.sv
// Port bundle for the two-requester APM share arbiter.
// Signal names are given from the arbiter's point of view.
interface ipsxe_floating_point_apm_share_arb_v1_0_if #(
  parameter int X_WIDTH = 28,
  parameter int Y_WIDTH = 18,
  parameter int Z_WIDTH = 48
) ();
  logic               i_req0_valid;
  logic               o_req0_ready;
  logic [X_WIDTH-1:0] i_req0_x;
  logic [Y_WIDTH-1:0] i_req0_y;
  logic [Z_WIDTH-1:0] i_req0_z;
  logic               i_req0_sub;

  logic               i_req1_valid;
  logic               o_req1_ready;
  logic [X_WIDTH-1:0] i_req1_x;
  logic [Y_WIDTH-1:0] i_req1_y;
  logic [Z_WIDTH-1:0] i_req1_z;
  logic               i_req1_sub;

  logic [X_WIDTH-1:0] o_apm_x;
  logic [Y_WIDTH-1:0] o_apm_y;
  logic [Z_WIDTH-1:0] o_apm_z;
  logic               o_apm_sub;
  logic [Z_WIDTH-1:0] i_apm_p;

  logic [Z_WIDTH-1:0] o_res_data;
  logic               o_res0_valid;
  logic               o_res1_valid;
  logic               o_busy;

  modport slave (
    input  i_req0_valid, i_req0_x, i_req0_y, i_req0_z, i_req0_sub,
    input  i_req1_valid, i_req1_x, i_req1_y, i_req1_z, i_req1_sub,
    input  i_apm_p,
    output o_req0_ready, o_req1_ready,
    output o_apm_x, o_apm_y, o_apm_z, o_apm_sub,
    output o_res_data, o_res0_valid, o_res1_valid, o_busy
  );

  modport master (
    output i_req0_valid, i_req0_x, i_req0_y, i_req0_z, i_req0_sub,
    output i_req1_valid, i_req1_x, i_req1_y, i_req1_z, i_req1_sub,
    output i_apm_p,
    input  o_req0_ready, o_req1_ready,
    input  o_apm_x, o_apm_y, o_apm_z, o_apm_sub,
    input  o_res_data, o_res0_valid, o_res1_valid, o_busy
  );
endinterface

// File: rtl/ipsxe_floating_point_apm_share_arb_v1_0.sv
// Round-robin arbiter sharing one pipelined APM (Z +/- X*Y) between two requesters.
// A tag pipeline tracks which requester owns each result coming back from the APM.
module ipsxe_floating_point_apm_share_arb_v1_0 #(
  parameter int X_WIDTH     = 28,
  parameter int Y_WIDTH     = 18,
  parameter int Z_WIDTH     = 48,
  parameter int APM_LATENCY = 1
) (
  input logic i_clk,
  input logic i_rst,
  ipsxe_floating_point_apm_share_arb_v1_0_if.slave bus
);

  localparam int LAST  = APM_LATENCY;
  localparam int CNT_W = $clog2(APM_LATENCY + 2);

  logic               grant0;
  logic               grant1;
  logic               xfer;
  logic               retire;

  logic               rrLast_q, rrLast_d;
  logic [X_WIDTH-1:0] apmX_q, apmX_d;
  logic [Y_WIDTH-1:0] apmY_q, apmY_d;
  logic [Z_WIDTH-1:0] apmZ_q, apmZ_d;
  logic               apmSub_q, apmSub_d;
  logic [LAST:0]      tagValid_q, tagValid_d;
  logic [LAST:0]      tagIdx_q, tagIdx_d;
  logic [Z_WIDTH-1:0] resData_q, resData_d;
  logic               res0Valid_q, res0Valid_d;
  logic               res1Valid_q, res1Valid_d;
  logic [CNT_W-1:0]   inFlight_q, inFlight_d;

  // Grants are suppressed during reset; rrLast_q names the last winner, so the other side wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_rst) begin
      grant0 = bus.i_req0_valid && (!bus.i_req1_valid || rrLast_q);
      grant1 = bus.i_req1_valid && (!bus.i_req0_valid || !rrLast_q);
    end
  end

  assign xfer   = grant0 || grant1;
  assign retire = tagValid_q[LAST];

  always_comb begin
    rrLast_d    = rrLast_q;
    apmX_d      = apmX_q;
    apmY_d      = apmY_q;
    apmZ_d      = apmZ_q;
    apmSub_d    = apmSub_q;
    tagValid_d  = '0;
    tagIdx_d    = '0;

    if (grant1) begin
      rrLast_d = 1'b1;
      apmX_d   = bus.i_req1_x;
      apmY_d   = bus.i_req1_y;
      apmZ_d   = bus.i_req1_z;
      apmSub_d = bus.i_req1_sub;
    end else if (grant0) begin
      rrLast_d = 1'b0;
      apmX_d   = bus.i_req0_x;
      apmY_d   = bus.i_req0_y;
      apmZ_d   = bus.i_req0_z;
      apmSub_d = bus.i_req0_sub;
    end

    // Idle cycles push a bubble so each tag stays aligned with its operands through the APM.
    tagValid_d[0] = xfer;
    tagIdx_d[0]   = grant1;
    for (int i = 1; i <= LAST; i++) begin
      tagValid_d[i] = tagValid_q[i-1];
      tagIdx_d[i]   = tagIdx_q[i-1];
    end

    resData_d   = retire ? bus.i_apm_p : resData_q;
    res0Valid_d = retire && !tagIdx_q[LAST];
    res1Valid_d = retire &&  tagIdx_q[LAST];
    inFlight_d  = inFlight_q + CNT_W'(xfer) - CNT_W'(retire);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rrLast_q    <= 1'b1;
      apmX_q      <= '0;
      apmY_q      <= '0;
      apmZ_q      <= '0;
      apmSub_q    <= 1'b0;
      tagValid_q  <= '0;
      tagIdx_q    <= '0;
      resData_q   <= '0;
      res0Valid_q <= 1'b0;
      res1Valid_q <= 1'b0;
      inFlight_q  <= '0;
    end else begin
      rrLast_q    <= rrLast_d;
      apmX_q      <= apmX_d;
      apmY_q      <= apmY_d;
      apmZ_q      <= apmZ_d;
      apmSub_q    <= apmSub_d;
      tagValid_q  <= tagValid_d;
      tagIdx_q    <= tagIdx_d;
      resData_q   <= resData_d;
      res0Valid_q <= res0Valid_d;
      res1Valid_q <= res1Valid_d;
      inFlight_q  <= inFlight_d;
    end
  end

  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;
  assign bus.o_apm_x      = apmX_q;
  assign bus.o_apm_y      = apmY_q;
  assign bus.o_apm_z      = apmZ_q;
  assign bus.o_apm_sub    = apmSub_q;
  assign bus.o_res_data   = resData_q;
  assign bus.o_res0_valid = res0Valid_q;
  assign bus.o_res1_valid = res1Valid_q;
  assign bus.o_busy       = (inFlight_q != '0);

endmodule

// File: tb/tb_ipsxe_floating_point_apm_share_arb_v1_0.sv
// Directed bench for the APM share arbiter: three instances (APM_LATENCY 0, 1, 3)
// driven by the same requesters, each with its own behavioural APM model.
module tb_ipsxe_floating_point_apm_share_arb_v1_0;

  localparam int XW = 28;
  localparam int YW = 18;
  localparam int ZW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0Valid, req1Valid, req0Sub, req1Sub;
  logic [XW-1:0] req0X, req1X;
  logic [YW-1:0] req0Y, req1Y;
  logic [ZW-1:0] req0Z, req1Z;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_apm_share_arb_v1_0_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW)) bus0 ();
  ipsxe_floating_point_apm_share_arb_v1_0_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW)) bus1 ();
  ipsxe_floating_point_apm_share_arb_v1_0_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW)) bus3 ();

  assign bus0.i_req0_valid = req0Valid; assign bus0.i_req1_valid = req1Valid;
  assign bus0.i_req0_x = req0X; assign bus0.i_req0_y = req0Y; assign bus0.i_req0_z = req0Z; assign bus0.i_req0_sub = req0Sub;
  assign bus0.i_req1_x = req1X; assign bus0.i_req1_y = req1Y; assign bus0.i_req1_z = req1Z; assign bus0.i_req1_sub = req1Sub;
  assign bus1.i_req0_valid = req0Valid; assign bus1.i_req1_valid = req1Valid;
  assign bus1.i_req0_x = req0X; assign bus1.i_req0_y = req0Y; assign bus1.i_req0_z = req0Z; assign bus1.i_req0_sub = req0Sub;
  assign bus1.i_req1_x = req1X; assign bus1.i_req1_y = req1Y; assign bus1.i_req1_z = req1Z; assign bus1.i_req1_sub = req1Sub;
  assign bus3.i_req0_valid = req0Valid; assign bus3.i_req1_valid = req1Valid;
  assign bus3.i_req0_x = req0X; assign bus3.i_req0_y = req0Y; assign bus3.i_req0_z = req0Z; assign bus3.i_req0_sub = req0Sub;
  assign bus3.i_req1_x = req1X; assign bus3.i_req1_y = req1Y; assign bus3.i_req1_z = req1Z; assign bus3.i_req1_sub = req1Sub;

  ipsxe_floating_point_apm_share_arb_v1_0 #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW), .APM_LATENCY(0))
    dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  ipsxe_floating_point_apm_share_arb_v1_0 #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW), .APM_LATENCY(1))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
  ipsxe_floating_point_apm_share_arb_v1_0 #(.X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW), .APM_LATENCY(3))
    dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3.slave));

  function automatic logic [ZW-1:0] apmModel(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                             input logic [ZW-1:0] z, input logic sub);
    logic [ZW-1:0] prod;
    prod = ZW'(x) * ZW'(y);
    return sub ? (z - prod) : (z + prod);
  endfunction

  // Shared APM models: combinational for latency 0, register chains otherwise.
  logic [ZW-1:0] p1;
  logic [ZW-1:0] p3 [3];
  assign bus0.i_apm_p = apmModel(bus0.o_apm_x, bus0.o_apm_y, bus0.o_apm_z, bus0.o_apm_sub);
  always_ff @(posedge clk) p1 <= apmModel(bus1.o_apm_x, bus1.o_apm_y, bus1.o_apm_z, bus1.o_apm_sub);
  assign bus1.i_apm_p = p1;
  always_ff @(posedge clk) begin
    p3[0] <= apmModel(bus3.o_apm_x, bus3.o_apm_y, bus3.o_apm_z, bus3.o_apm_sub);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.i_apm_p = p3[2];

  typedef struct {
    logic          v0, v1, s0, s1;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [ZW-1:0] z0, z1;
    logic          r0, r1, res0, res1, busy;
    logic [ZW-1:0] data;
  } vec_t;

  function automatic vec_t mkVec(input int v0, v1, x0, y0, z0, s0, x1, y1, z1, s1,
                                 input int r0, r1, q0, q1, input longint d, input int b);
    vec_t v;
    v.v0 = 1'(v0); v.v1 = 1'(v1); v.s0 = 1'(s0); v.s1 = 1'(s1);
    v.x0 = XW'(x0); v.y0 = YW'(y0); v.z0 = ZW'(z0);
    v.x1 = XW'(x1); v.y1 = YW'(y1); v.z1 = ZW'(z1);
    v.r0 = 1'(r0); v.r1 = 1'(r1); v.res0 = 1'(q0); v.res1 = 1'(q1);
    v.data = ZW'(d); v.busy = 1'(b);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req0Valid = v.v0; req0X = v.x0; req0Y = v.y0; req0Z = v.z0; req0Sub = v.s0;
    req1Valid = v.v1; req1X = v.x1; req1Y = v.y1; req1Z = v.z1; req1Sub = v.s1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  vec_t vecs[18];
  int   patV[4]      = '{1, 0, 1, 1};
  int   opX[4]       = '{1, 0, 2, 3};
  int   exp0Res[10]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
  int   exp0Data[10] = '{0, 0, 1, 1, 2, 3, 3, 3, 3, 3};
  int   exp0Busy[10] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
  int   exp3Res[10]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
  int   exp3Data[10] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 3};
  int   exp3Busy[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ready0"}, 64'(bus1.o_req0_ready), 64'd0);
    checkOutput({tag, " ready1"}, 64'(bus1.o_req1_ready), 64'd0);
    checkOutput({tag, " apm_x"}, 64'(bus1.o_apm_x), 64'd0);
    checkOutput({tag, " apm_y"}, 64'(bus1.o_apm_y), 64'd0);
    checkOutput({tag, " apm_z"}, 64'(bus1.o_apm_z), 64'd0);
    checkOutput({tag, " apm_sub"}, 64'(bus1.o_apm_sub), 64'd0);
    checkOutput({tag, " res_data"}, 64'(bus1.o_res_data), 64'd0);
    checkOutput({tag, " res0_valid"}, 64'(bus1.o_res0_valid), 64'd0);
    checkOutput({tag, " res1_valid"}, 64'(bus1.o_res1_valid), 64'd0);
    checkOutput({tag, " busy"}, 64'(bus1.o_busy), 64'd0);
    checkOutput({tag, " busy L3"}, 64'(bus3.o_busy), 64'd0);
    checkOutput({tag, " res0_valid L3"}, 64'(bus3.o_res0_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(mkVec(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));

    //              v0 v1  x0 y0 z0 s0   x1 y1 z1 s1  r0 r1 q0 q1 data busy
    vecs[0]  = mkVec(1,0,  3,5,100,0,   0,0,0,0,      1,0, 0,0, 0,   0);
    vecs[1]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,0, 0,   1);
    vecs[2]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,0, 0,   1);
    vecs[3]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 1,0, 115, 0);
    vecs[4]  = mkVec(0,1,  0,0,0,0,     2,7,20,1,     0,1, 0,0, 115, 0);
    vecs[5]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,0, 115, 1);
    vecs[6]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,0, 115, 1);
    vecs[7]  = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,1, 6,   0);
    vecs[8]  = mkVec(1,1,  1,1,10,0,    1,2,100,0,    1,0, 0,0, 6,   0);
    vecs[9]  = mkVec(1,1,  2,2,10,0,    1,2,100,0,    0,1, 0,0, 6,   1);
    vecs[10] = mkVec(1,1,  2,2,10,0,    3,3,100,1,    1,0, 0,0, 6,   1);
    vecs[11] = mkVec(1,1,  5,5,0,0,     3,3,100,1,    0,1, 1,0, 11,  1);
    vecs[12] = mkVec(1,1,  5,5,0,0,     6,6,36,1,     1,0, 0,1, 102, 1);
    vecs[13] = mkVec(1,1,  7,1,1,1,     6,6,36,1,     0,1, 1,0, 14,  1);
    vecs[14] = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,1, 91,  1);
    vecs[15] = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 1,0, 25,  1);
    vecs[16] = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,1, 0,   0);
    vecs[17] = mkVec(0,0,  0,0,0,0,     0,0,0,0,      0,0, 0,0, 0,   0);

    // Power-on reset with both requesters asserting valid.
    #1 rst = 1'b1;
    req0Valid = 1'b1; req1Valid = 1'b1; req0X = XW'(5);
    #1 checkResetState("por");
    repeat (2) @(posedge clk);
    #1 checkResetState("por held");
    @(negedge clk);
    rst = 1'b0;
    req0Valid = 1'b0; req1Valid = 1'b0;

    // Single ops, subtract, 6-cycle contention, drain (latency 1 instance).
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d ready0", i), 64'(bus1.o_req0_ready), 64'(vecs[i].r0));
      checkOutput($sformatf("row%0d ready1", i), 64'(bus1.o_req1_ready), 64'(vecs[i].r1));
      checkOutput($sformatf("row%0d res0_valid", i), 64'(bus1.o_res0_valid), 64'(vecs[i].res0));
      checkOutput($sformatf("row%0d res1_valid", i), 64'(bus1.o_res1_valid), 64'(vecs[i].res1));
      checkOutput($sformatf("row%0d res_data", i), 64'(bus1.o_res_data), 64'(vecs[i].data));
      checkOutput($sformatf("row%0d busy", i), 64'(bus1.o_busy), 64'(vecs[i].busy));
    end

    repeat (4) begin
      @(negedge clk);
      applyStimulus(mkVec(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
    end

    // Valid pattern 1,0,1,1 on req0 against the latency-0 and latency-3 instances.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req1Valid = 1'b0;
      req0Valid = (c < 4) ? 1'(patV[c]) : 1'b0;
      req0X = (c < 4) ? XW'(opX[c]) : '0;
      req0Y = YW'(1); req0Z = '0; req0Sub = 1'b0;
      #1;
      checkOutput($sformatf("bub%0d ready0", c), 64'(bus0.o_req0_ready), (c < 4) ? 64'(patV[c]) : 64'd0);
      checkOutput($sformatf("bub%0d L0 res0", c), 64'(bus0.o_res0_valid), 64'(exp0Res[c]));
      checkOutput($sformatf("bub%0d L0 res1", c), 64'(bus0.o_res1_valid), 64'd0);
      checkOutput($sformatf("bub%0d L0 data", c), 64'(bus0.o_res_data), 64'(exp0Data[c]));
      checkOutput($sformatf("bub%0d L0 busy", c), 64'(bus0.o_busy), 64'(exp0Busy[c]));
      checkOutput($sformatf("bub%0d L3 res0", c), 64'(bus3.o_res0_valid), 64'(exp3Res[c]));
      checkOutput($sformatf("bub%0d L3 res1", c), 64'(bus3.o_res1_valid), 64'd0);
      checkOutput($sformatf("bub%0d L3 data", c), 64'(bus3.o_res_data), 64'(exp3Data[c]));
      checkOutput($sformatf("bub%0d L3 busy", c), 64'(bus3.o_busy), 64'(exp3Busy[c]));
    end

    // Two ops in flight, then reset before either result returns.
    @(negedge clk);
    applyStimulus(mkVec(1,0, 9,9,0,0, 0,0,0,0, 0,0,0,0, 0,0));
    @(negedge clk);
    applyStimulus(mkVec(0,1, 0,0,0,0, 8,3,100,1, 0,0,0,0, 0,0));
    @(negedge clk);
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1 checkOutput("pre-reset busy", 64'(bus1.o_busy), 64'd1);
    rst = 1'b1;
    #1 checkResetState("midflight");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 checkResetState($sformatf("midflight hold%0d", c));
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mkVec(1,1, 4,4,4,0, 1,1,1,0, 0,0,0,0, 0,0));
    #1;
    checkOutput("post-reset ready0", 64'(bus1.o_req0_ready), 64'd1);
    checkOutput("post-reset ready1", 64'(bus1.o_req1_ready), 64'd0);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      req0Valid = 1'b0; req1Valid = 1'b0;
      #1;
      checkOutput($sformatf("post%0d res0", c), 64'(bus1.o_res0_valid), (c == 3) ? 64'd1 : 64'd0);
      checkOutput($sformatf("post%0d res1", c), 64'(bus1.o_res1_valid), 64'd0);
      checkOutput($sformatf("post%0d data", c), 64'(bus1.o_res_data), (c >= 3) ? 64'd20 : 64'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
